// File: rtl/dither_ctrl.sv
// Frame-synchronous dither controller: defers config writes to the next frame
// start, derives per-channel dither enables and re-times sync/DE to the dither stages.
module dither_ctrl #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ALIGN_LAT = 1,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] cfg_chmask,
  input  logic              pix_ce,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              dith_ce,
  output logic [NUM_CH-1:0] dith_en,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              cfg_pending,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t state, state_n;

  logic [1:0]        mode_p, mode_a;
  logic [NUM_CH-1:0] mask_p, mask_a;
  logic              vs_prev;
  logic              vs_low_seen;
  logic              fs;
  logic              apply;
  logic              frame_on;
  logic              mode_sel;

  function automatic logic mode_on(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd2);
  endfunction

  // vs_low_seen keeps a vs already high when reset releases from counting as a frame start
  assign fs    = pix_ce & vs_in & ~vs_prev & vs_low_seen;
  assign apply = fs & cfg_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_OFF;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_OFF: begin
        if (cfg_wr && mode_on(cfg_mode)) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (fs) begin
          if (mode_on(mode_p))                state_n = S_RUN;
          else if (cfg_wr && mode_on(cfg_mode)) state_n = S_ARMED;
          else                                 state_n = S_OFF;
        end
      end
      S_RUN: begin
        // turning off while a coincident write re-enables goes straight back to waiting
        if (apply && !mode_on(mode_p)) begin
          state_n = (cfg_wr && mode_on(cfg_mode)) ? S_ARMED : S_OFF;
        end
      end
      default: state_n = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_p      <= '0;
      mask_p      <= '0;
      mode_a      <= '0;
      mask_a      <= '0;
      cfg_pending <= 1'b0;
      frame_cnt   <= '0;
      vs_prev     <= 1'b0;
      vs_low_seen <= 1'b0;
    end else begin
      if (apply) begin
        mode_a <= mode_p;
        mask_a <= mask_p;
      end
      // a write landing on the frame start stays pending for the following frame
      if (cfg_wr) begin
        mode_p      <= cfg_mode;
        mask_p      <= cfg_chmask;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
      if (fs) frame_cnt <= frame_cnt + FCNT_W'(1);
      if (pix_ce) begin
        vs_prev <= vs_in;
        if (!vs_in) vs_low_seen <= 1'b1;
      end
    end
  end

  assign frame_on = ~frame_cnt[0];
  assign mode_sel = (mode_a == 2'd1) || ((mode_a == 2'd2) && frame_on);

  assign dith_ce = pix_ce;
  assign dith_en = (state == S_RUN && mode_sel && de_in) ? mask_a : '0;
  assign state_o = state;

  logic [2:0]             tim_in;
  logic [3*ALIGN_LAT-1:0] dly;

  assign tim_in = {de_in, hs_in, vs_in};

  generate
    if (ALIGN_LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (reset)       dly <= '0;
        else if (pix_ce) dly <= tim_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset)       dly <= '0;
        else if (pix_ce) dly <= {dly[3*ALIGN_LAT-4:0], tim_in};
      end
    end
  endgenerate

  assign {de_out, hs_out, vs_out} = dly[3*ALIGN_LAT-1 -: 3];

endmodule

// File: tb/tb_dither_ctrl.sv
// Self-checking bench for dither_ctrl: small synthetic frames, scoreboard queues
// of expected dither enables and delayed timing, one task per scenario.
module tb_dither_ctrl;

  localparam int LINES = 4;
  localparam int PIX   = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_wr;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_chmask;
  logic       pix_ce;
  logic       de_in, hs_in, vs_in;
  logic       dith_ce;
  logic [2:0] dith_en;
  logic       de_out, hs_out, vs_out;
  logic       cfg_pending;
  logic [7:0] frame_cnt;
  logic [1:0] state_o;

  dither_ctrl #(.NUM_CH(3), .ALIGN_LAT(1), .FCNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode),
    .cfg_chmask(cfg_chmask), .pix_ce(pix_ce), .de_in(de_in), .hs_in(hs_in),
    .vs_in(vs_in), .dith_ce(dith_ce), .dith_en(dith_en), .de_out(de_out),
    .hs_out(hs_out), .vs_out(vs_out), .cfg_pending(cfg_pending),
    .frame_cnt(frame_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_fcnt;
  logic [2:0] tim_hold;
  logic [2:0] e, o;
  logic [2:0] en_exp_q[$], en_obs_q[$], tim_exp_q[$], tim_obs_q[$], tim_pipe[$];

  function automatic logic [2:0] geom(input int l, input int p);
    logic de, hs, vs;
    de = (l >= 1) && (p >= 1) && (p <= 4);
    hs = (p == 0);
    vs = (l == 0);
    return {de, hs, vs};
  endfunction

  // one clk cycle: drive, push expectations, sample at negedge, return at posedge+1
  task automatic cycle(input logic [2:0] t, input logic ce, input logic wr,
                       input logic [1:0] m, input logic [2:0] k, input logic [2:0] en);
    {de_in, hs_in, vs_in} = t;
    pix_ce = ce; cfg_wr = wr; cfg_mode = m; cfg_chmask = k;
    en_exp_q.push_back(t[2] ? en : 3'b000);
    tim_exp_q.push_back(tim_hold);
    if (ce) tim_pipe.push_back(t);
    @(negedge clk);
    en_obs_q.push_back(dith_en);
    tim_obs_q.push_back({de_out, hs_out, vs_out});
    @(posedge clk); #1;
    if (ce) tim_hold = tim_pipe.pop_front();
    cfg_wr = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] en, input int ce_div,
                           input int wa, input logic [1:0] ma, input logic [2:0] ka,
                           input int wb, input logic [1:0] mb, input logic [2:0] kb);
    logic wr; logic [1:0] m; logic [2:0] k;
    for (int l = 0; l < LINES; l++)
      for (int p = 0; p < PIX; p++)
        for (int c = 0; c < ce_div; c++) begin
          wr = 1'b0; m = 2'd0; k = 3'd0;
          if (c == 0 && l*PIX+p == wa) begin wr = 1'b1; m = ma; k = ka; end
          if (c == 0 && l*PIX+p == wb) begin wr = 1'b1; m = mb; k = kb; end
          cycle(geom(l, p), c == 0, wr, m, k, en);
        end
    exp_fcnt = exp_fcnt + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_wr = 1'b1; cfg_mode = 2'd1; cfg_chmask = 3'b111;
    pix_ce = 1'b1; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL reset_state got=%b exp=00", state_o); end
    tests++; if (cfg_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", cfg_pending); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt); end
    tests++; if (dith_en !== 3'b000) begin fails++; $display("FAIL reset_en got=%b exp=000", dith_en); end
    tests++; if ({de_out, hs_out, vs_out} !== 3'b000) begin fails++; $display("FAIL reset_tim got=%b exp=000", {de_out, hs_out, vs_out}); end
    tests++; if (dith_ce !== 1'b1) begin fails++; $display("FAIL reset_ce got=%b exp=1", dith_ce); end
    @(posedge clk); #1;
    reset = 1'b0; cfg_wr = 1'b0;
    tim_pipe.delete(); tim_hold = 3'b000; exp_fcnt = 8'd0;
    cycle(3'b000, 1'b1, 1'b0, 2'd0, 3'd0, 3'b000);
    cycle(3'b000, 1'b1, 1'b0, 2'd0, 3'd0, 3'b000);
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL idle_en got=%b exp=%b", o, e); end
    end
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL idle_state got=%b exp=00", state_o); end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_arm_spatial();
    run_frame(3'b000, 1, 8, 2'd1, 3'b111, -1, 2'd0, 3'd0);
    tests++; if (state_o !== 2'b01) begin fails++; $display("FAIL arm_state got=%b exp=01", state_o); end
    tests++; if (cfg_pending !== 1'b1) begin fails++; $display("FAIL arm_pending got=%b exp=1", cfg_pending); end
    repeat (2) run_frame(3'b111, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    tests++; if (state_o !== 2'b10) begin fails++; $display("FAIL run_state got=%b exp=10", state_o); end
    tests++; if (cfg_pending !== 1'b0) begin fails++; $display("FAIL run_pending got=%b exp=0", cfg_pending); end
    tests++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL spatial_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL spatial_en got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_temporal();
    logic [7:0] nxt;
    run_frame(3'b111, 1, 3, 2'd2, 3'b101, -1, 2'd0, 3'd0);
    for (int f = 0; f < 4; f++) begin
      nxt = exp_fcnt + 8'd1;
      run_frame(nxt[0] ? 3'b000 : 3'b101, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    end
    tests++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL temporal_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL temporal_en got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_last_write_wins();
    logic [7:0] nxt;
    nxt = exp_fcnt + 8'd1;
    run_frame(nxt[0] ? 3'b000 : 3'b101, 1, 2, 2'd1, 3'b111, 14, 2'd0, 3'b111);
    tests++; if (cfg_pending !== 1'b1) begin fails++; $display("FAIL lww_pending got=%b exp=1", cfg_pending); end
    tests++; if (state_o !== 2'b10) begin fails++; $display("FAIL lww_state_run got=%b exp=10", state_o); end
    run_frame(3'b000, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    tests++; if (cfg_pending !== 1'b0) begin fails++; $display("FAIL lww_pending_clr got=%b exp=0", cfg_pending); end
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL lww_state_off got=%b exp=00", state_o); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL lww_en got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_coincident();
    run_frame(3'b000, 1, 10, 2'd1, 3'b011, -1, 2'd0, 3'd0);
    tests++; if (state_o !== 2'b01) begin fails++; $display("FAIL coin_armed got=%b exp=01", state_o); end
    run_frame(3'b011, 1, 0, 2'd1, 3'b110, -1, 2'd0, 3'd0);
    tests++; if (cfg_pending !== 1'b1) begin fails++; $display("FAIL coin_pending got=%b exp=1", cfg_pending); end
    tests++; if (state_o !== 2'b10) begin fails++; $display("FAIL coin_state got=%b exp=10", state_o); end
    run_frame(3'b110, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    tests++; if (cfg_pending !== 1'b0) begin fails++; $display("FAIL coin_pending_clr got=%b exp=0", cfg_pending); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL coin_en got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_timing_ce();
    tim_exp_q.delete(); tim_obs_q.delete();
    repeat (2) run_frame(3'b110, 3, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    while (tim_exp_q.size() != 0) begin
      e = tim_exp_q.pop_front(); o = tim_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL tim_delay got=%b exp=%b", o, e); end
    end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL tim_en got=%b exp=%b", o, e); end
    end
    tests++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL tim_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
  endtask

  task automatic test_fcnt_wrap();
    while (exp_fcnt != 8'd255) begin
      run_frame(3'b110, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
      while (en_exp_q.size() != 0) begin
        e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
        if (o !== e) begin fails++; $display("FAIL wrap_en got=%b exp=%b", o, e); end
      end
      tim_exp_q.delete(); tim_obs_q.delete();
    end
    tests++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255 got=%0d exp=255", frame_cnt); end
    run_frame(3'b110, 1, -1, 2'd0, 3'd0, -1, 2'd0, 3'd0);
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0 got=%0d exp=0", frame_cnt); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL wrap_last_en got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    for (int p = 0; p < PIX; p++) cycle(geom(1, p), 1'b1, 1'b0, 2'd0, 3'd0, 3'b110);
    reset = 1'b1; pix_ce = 1'b1; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b1;
    @(posedge clk); #1;
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL rmid_state got=%b exp=00", state_o); end
    tests++; if (dith_en !== 3'b000) begin fails++; $display("FAIL rmid_en got=%b exp=000", dith_en); end
    tests++; if ({de_out, hs_out, vs_out} !== 3'b000) begin fails++; $display("FAIL rmid_tim got=%b exp=000", {de_out, hs_out, vs_out}); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL rmid_fcnt got=%0d exp=0", frame_cnt); end
    reset = 1'b0;
    tim_pipe.delete(); tim_hold = 3'b000; exp_fcnt = 8'd0;
    repeat (3) cycle(3'b101, 1'b1, 1'b0, 2'd0, 3'd0, 3'b000);
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL rmid_no_fs got=%0d exp=0", frame_cnt); end
    cycle(3'b100, 1'b1, 1'b0, 2'd0, 3'd0, 3'b000);
    cycle(3'b001, 1'b1, 1'b0, 2'd0, 3'd0, 3'b000);
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL rmid_first_fs got=%0d exp=1", frame_cnt); end
    tests++; if (state_o !== 2'b00) begin fails++; $display("FAIL rmid_state_after got=%b exp=00", state_o); end
    while (en_exp_q.size() != 0) begin
      e = en_exp_q.pop_front(); o = en_obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL rmid_en_seq got=%b exp=%b", o, e); end
    end
    tim_exp_q.delete(); tim_obs_q.delete();
  endtask

  initial begin
    reset = 1'b1; cfg_wr = 1'b0; cfg_mode = 2'd0; cfg_chmask = 3'd0;
    pix_ce = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    tim_hold = 3'b000; exp_fcnt = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_arm_spatial();
    test_temporal();
    test_last_write_wins();
    test_coincident();
    test_timing_ce();
    test_fcnt_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
